// File: rtl/ps_frame_tx_scheduler.sv
// Two-source frame scheduler: round-robin grant, eight payload bytes plus a CRC-8 trailer
// on a valid/ready byte stream, then an enforced idle gap before the next grant.
module ps_frame_tx_scheduler #(
    parameter logic [7:0]  POLYNOMIAL = 8'h07,
    parameter logic [7:0]  INITIAL    = 8'hFF,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] payload0,
    input  logic [63:0] payload1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  byte_counter,
    output logic        busy,
    output logic [1:0]  o_state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_CRC  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_shift;
    logic [7:0]  r_crc;
    logic [3:0]  r_byte_cnt;
    logic [3:0]  r_gap_cnt;
    logic        r_owner;
    logic        r_prio;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        w_any_req;
    logic        w_win;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
        end
        return c;
    endfunction

    // r_prio names the source that wins when both request at once.
    assign w_any_req = req0 | req1;
    assign w_win     = (req0 && req1) ? r_prio : req1;

    // Stream handshake: a byte transfers on a rising edge where tx_valid and tx_ready are
    // both high; while tx_valid is high and tx_ready low, tx_valid and tx_data hold steady.
    // Both are decoded from registered state only, so a stall cannot disturb them.
    always_comb begin
        w_next       = r_state;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        done0        = 1'b0;
        done1        = 1'b0;
        busy         = (r_state != S_IDLE);
        gnt0         = r_gnt0;
        gnt1         = r_gnt1;
        byte_counter = r_byte_cnt;
        o_state_dbg  = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_next = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = r_shift[63:56];
                if (tx_ready && r_byte_cnt == 4'd7) w_next = S_CRC;
            end
            S_CRC: begin
                tx_valid = 1'b1;
                tx_data  = r_crc;
                done0    = tx_ready & ~r_owner;
                done1    = tx_ready & r_owner;
                if (tx_ready) w_next = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shift    <= 64'h0;
            r_crc      <= INITIAL;
            r_byte_cnt <= 4'd0;
            r_gap_cnt  <= 4'd0;
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_win;
                        r_prio     <= ~w_win;
                        r_shift    <= w_win ? payload1 : payload0;
                        r_crc      <= INITIAL;
                        r_byte_cnt <= 4'd0;
                        r_gnt0     <= ~w_win;
                        r_gnt1     <= w_win;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_crc      <= crc8_byte(r_crc, r_shift[63:56]);
                        r_shift    <= {r_shift[55:0], 8'h00};
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                S_CRC: begin
                    if (tx_ready) begin
                        r_byte_cnt <= 4'd0;
                        r_gap_cnt  <= 4'd0;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps_frame_tx_scheduler.sv
// Directed bench for ps_frame_tx_scheduler: single frames, CRC trailer, round-robin,
// back-pressure, mid-frame reset and a request withdrawn during the gap.
module tb_ps_frame_tx_scheduler;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [63:0] payload0, payload1;
    logic        gnt0, gnt1, done0, done1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  byte_counter;
    logic        busy;
    logic [1:0]  o_state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    ps_frame_tx_scheduler #(
        .POLYNOMIAL(8'h07),
        .INITIAL   (8'hFF),
        .GAP_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .payload0    (payload0),
        .payload1    (payload1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .byte_counter(byte_counter),
        .busy        (busy),
        .o_state_dbg (o_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC-8 computed one message bit at a time through a feedback register.
    function automatic logic [7:0] model_crc(input logic [63:0] p);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 63; i >= 0; i--) begin
            fb = c[7] ^ p[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        req0     = 1'b1;
        payload0 = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, done0, done1, tx_valid, busy} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, tx_valid, busy});
        else n_pass++;
        n_checks++;
        if ({tx_data, byte_counter, o_state_dbg} !== 14'h0)
            $display("FAIL reset_data: got data=%h cnt=%0d st=%0d want 0", tx_data, byte_counter, o_state_dbg);
        else n_pass++;
        req0  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_exit_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_single_frame;
        logic [7:0] exp_d;
        int         gap;
        bit         bad_gap;
        @(negedge clk);
        payload0 = 64'hFF00_0000_0000_0000;
        req0     = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, o_state_dbg} !== 4'b10_01)
            $display("FAIL single_gnt: got gnt=%b%b st=%0d want 10 st=1", gnt0, gnt1, o_state_dbg);
        else n_pass++;
        req0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            exp_d = (i == 0) ? 8'hFF : 8'h00;
            n_checks++;
            if ({tx_valid, tx_data, byte_counter, done0, done1} !== {1'b1, exp_d, 4'(i), (i == 8), 1'b0})
                $display("FAIL single_byte%0d: got v=%b d=%h c=%0d dn=%b%b want v=1 d=%h c=%0d dn=%b0",
                         i, tx_valid, tx_data, byte_counter, done0, done1, exp_d, i, (i == 8));
            else n_pass++;
        end
        gap     = 0;
        bad_gap = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!busy) break;
            if (tx_valid) bad_gap = 1'b1;
            gap++;
        end
        n_checks++;
        if (gap !== 4 || bad_gap || busy !== 1'b0)
            $display("FAIL single_gap: got gap=%0d valid_in_gap=%b busy=%b want 4 0 0", gap, bad_gap, busy);
        else n_pass++;
    endtask

    task automatic test_crc_07;
        logic [7:0] exp_d;
        bit         ok;
        @(negedge clk);
        payload0 = 64'hFF00_0000_0000_0001;
        req0     = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) $display("FAIL crc07_gnt: got %b want 1", gnt0);
        else n_pass++;
        req0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            exp_d = (i == 0) ? 8'hFF : (i == 7) ? 8'h01 : (i == 8) ? 8'h07 : 8'h00;
            n_checks++;
            if ({tx_valid, tx_data, byte_counter, done0} !== {1'b1, exp_d, 4'(i), (i == 8)})
                $display("FAIL crc07_byte%0d: got v=%b d=%h c=%0d dn=%b want v=1 d=%h c=%0d dn=%b",
                         i, tx_valid, tx_data, byte_counter, done0, exp_d, i, (i == 8));
            else n_pass++;
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL crc07_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        int         n_g;
        int         t;
        int         g_src[3];
        int         g_t[3];
        bit         overlap;
        logic [7:0] crc1_seen;
        bit         ok;
        do_reset();
        payload0  = 64'hFF00_0000_0000_0001;
        payload1  = 64'h0102_0304_0506_0708;
        req0      = 1'b1;
        req1      = 1'b1;
        n_g       = 0;
        overlap   = 1'b0;
        crc1_seen = 8'h00;
        for (t = 0; t < 60 && n_g < 3; t++) begin
            @(negedge clk);
            if ((gnt0 && gnt1) || (done0 && done1)) overlap = 1'b1;
            if (done1) crc1_seen = tx_data;
            if (gnt0 || gnt1) begin
                g_src[n_g] = gnt1 ? 1 : 0;
                g_t[n_g]   = t;
                n_g++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_checks++;
        if (n_g !== 3) $display("FAIL rr_count: got %0d grants want 3", n_g);
        else n_pass++;
        if (n_g == 3) begin
            n_checks++;
            if ({g_src[0][0], g_src[1][0], g_src[2][0]} !== 3'b010)
                $display("FAIL rr_order: got %0d,%0d,%0d want 0,1,0", g_src[0], g_src[1], g_src[2]);
            else n_pass++;
            n_checks++;
            if ((g_t[1] - g_t[0]) !== 14 || (g_t[2] - g_t[1]) !== 14)
                $display("FAIL rr_spacing: got %0d,%0d want 14,14", g_t[1] - g_t[0], g_t[2] - g_t[1]);
            else n_pass++;
        end
        n_checks++;
        if (overlap) $display("FAIL rr_exclusive: got both sources pulsed in one cycle want never");
        else n_pass++;
        n_checks++;
        if (crc1_seen !== model_crc(payload1))
            $display("FAIL rr_crc1: got %h want %h", crc1_seen, model_crc(payload1));
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL rr_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int         idx;
        logic [7:0] exp_d;
        bit         ok;
        @(negedge clk);
        payload0 = 64'h1122_3344_5566_7788;
        req0     = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) $display("FAIL bp_gnt: got %b want 1", gnt0);
        else n_pass++;
        req0 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            idx   = (c < 3) ? c : (c <= 6) ? 3 : c - 3;
            exp_d = (idx < 8) ? payload0[63 - 8 * idx -: 8] : model_crc(payload0);
            n_checks++;
            if ({tx_valid, tx_data, byte_counter, done0} !== {1'b1, exp_d, 4'(idx), (c == 11)})
                $display("FAIL bp_cycle%0d: got v=%b d=%h c=%0d dn=%b want v=1 d=%h c=%0d dn=%b",
                         c, tx_valid, tx_data, byte_counter, done0, exp_d, idx, (c == 11));
            else n_pass++;
            tx_ready = !(c >= 3 && c <= 5);
        end
        tx_ready = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL bp_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        bit         dn_seen;
        logic [7:0] exp_d;
        bit         ok;
        @(negedge clk);
        payload0 = 64'hA5A5_A5A5_A5A5_A5A5;
        req0     = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (byte_counter !== 4'd5) $display("FAIL rst_mid_pos: got cnt=%0d want 5", byte_counter);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({tx_valid, tx_data, byte_counter, busy, gnt0, done0, o_state_dbg} !== 17'h0)
            $display("FAIL rst_mid_async: got v=%b d=%h c=%0d busy=%b st=%0d want all 0",
                     tx_valid, tx_data, byte_counter, busy, o_state_dbg);
        else n_pass++;
        dn_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1 || tx_valid) dn_seen = 1'b1;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1 || tx_valid) dn_seen = 1'b1;
        end
        n_checks++;
        if (dn_seen) $display("FAIL rst_mid_nodone: got done/valid after reset want none");
        else n_pass++;
        payload0 = 64'hFF00_0000_0000_0001;
        req0     = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) $display("FAIL rst_mid_regrant: got %b want 1", gnt0);
        else n_pass++;
        req0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            exp_d = (i == 0) ? 8'hFF : (i == 7) ? 8'h01 : (i == 8) ? 8'h07 : 8'h00;
            n_checks++;
            if ({tx_valid, tx_data, byte_counter, done0} !== {1'b1, exp_d, 4'(i), (i == 8)})
                $display("FAIL rst_mid_byte%0d: got v=%b d=%h c=%0d dn=%b want v=1 d=%h c=%0d dn=%b",
                         i, tx_valid, tx_data, byte_counter, done0, exp_d, i, (i == 8));
            else n_pass++;
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL rst_mid_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_gap_request_drop;
        bit in_gap;
        int n_gnt1;
        bit fell;
        @(negedge clk);
        payload0 = 64'h0F0F_0F0F_0F0F_0F0F;
        req0     = 1'b1;
        @(negedge clk);
        req0   = 1'b0;
        in_gap = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy && !tx_valid) begin
                in_gap = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!in_gap) $display("FAIL gap_reach: got no gap state want gap");
        else n_pass++;
        req1 = 1'b1;
        @(negedge clk);
        req1   = 1'b0;
        n_gnt1 = 0;
        fell   = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (gnt1) n_gnt1++;
            if (!busy) fell = 1'b1;
        end
        n_checks++;
        if (n_gnt1 !== 0) $display("FAIL gap_nogrant: got %0d gnt1 pulses want 0", n_gnt1);
        else n_pass++;
        n_checks++;
        if (!fell || busy !== 1'b0) $display("FAIL gap_busy_fall: got fell=%b busy=%b want 1 0", fell, busy);
        else n_pass++;
    endtask

    initial begin
        reset    = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        payload0 = 64'h0;
        payload1 = 64'h0;
        tx_ready = 1'b1;
        test_reset();
        test_single_frame();
        test_crc_07();
        test_round_robin();
        test_backpressure();
        test_reset_mid_frame();
        test_gap_request_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps_frame_tx_scheduler.md
PS_FRAME_TX_SCHEDULER -- requirements
Module: ps_frame_tx_scheduler

Interface
REQ-001 SHALL have parameter POLYNOMIAL, default 8'h07, CRC-8 generator polynomial (MSB-first, non-reflected).
REQ-002 SHALL have parameter INITIAL, default 8'hFF, CRC seed loaded at each frame start.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle cycles enforced after each frame (range 1..15).
REQ-004 SHALL have port clk input 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset input 1: asynchronous, active-low reset.
REQ-006 SHALL have ports req0 and req1, input 1: per-source frame request, level, held until its grant.
REQ-007 SHALL have ports payload0 and payload1, input 64: 8-byte payload per source; byte 0 in [63:56], sent first.
REQ-008 SHALL have ports gnt0 and gnt1, output 1: one-cycle pulse when that source's payload is captured.
REQ-009 SHALL have ports done0 and done1, output 1: one-cycle pulse when that source's CRC byte is accepted downstream.
REQ-010 SHALL have port tx_data output 8: byte presented to the serializer.
REQ-011 SHALL have port tx_valid output 1: tx_data is valid.
REQ-012 SHALL have port tx_ready input 1: downstream accepts the byte when tx_valid and tx_ready are both high at a rising edge.
REQ-013 SHALL have port byte_counter output 4: index of the byte presented (0..8); 0 outside SEND/CRC.
REQ-014 SHALL have port busy output 1: high in every state except IDLE.

Function
REQ-015 SHALL use states IDLE, SEND, CRC, GAP.
REQ-016 IDLE: if any reqN is high, SHALL capture the winner's payload into a 64-bit shift register, load crc=INITIAL, pulse gntN, and enter SEND next cycle, with byte_counter=0.
REQ-017 Arbitration SHALL be round-robin: with both requests high, grant the source not granted last; after reset, source 0 has priority.
REQ-018 SEND: tx_valid=1 and tx_data=shift[63:56]; on acceptance SHALL update crc=crc8(crc XOR byte) bitwise MSB-first with POLYNOMIAL, shift payload left 8, and increment byte_counter.
REQ-019 On acceptance of byte 7, SHALL enter CRC with byte_counter=8.
REQ-020 CRC: tx_valid=1, tx_data=accumulated crc; on acceptance SHALL pulse doneN for the frame's owner and enter GAP.
REQ-021 tx_data and tx_valid SHALL remain stable while tx_valid=1 and tx_ready=0 (no retraction, no byte change).
REQ-022 Each accepted byte SHALL cost exactly one cycle; with tx_ready held high a frame occupies 9 cycles of tx_valid, no bubbles between bytes.
REQ-023 GAP: tx_valid=0; SHALL count GAP_CYCLES cycles then return to IDLE; requests arriving during SEND/CRC/GAP SHALL wait and are not dropped.
REQ-024 Minimum grant-to-grant spacing with tx_ready=1 SHALL be 1 + 9 + GAP_CYCLES cycles.
REQ-025 gnt and done pulses SHALL never be asserted for both sources in the same cycle; only one frame is in flight.
REQ-026 Deassertion of the owner's reqN after grant SHALL NOT abort the frame.
REQ-027 Requests SHALL be sampled only in IDLE; a request that drops before IDLE is never granted.

Reset
REQ-028 On reset low, SHALL asynchronously force state=IDLE, tx_valid=0, tx_data=8'h00, byte_counter=0, gnt0/gnt1/done0/done1=0, busy=0, crc=INITIAL, round-robin pointer to source 0.
REQ-029 Reset mid-frame SHALL abandon the frame without emitting a CRC byte or done pulse; the first post-reset grant starts a fresh frame.
REQ-030 SHALL leave reset synchronously on the first clk edge after reset rises, granting only in IDLE.

Verification
REQ-031 req0=1, payload0=64'hFF00_0000_0000_0000, tx_ready=1 -> gnt0 pulse; tx_data FF,00,00,00,00,00,00,00,00 on 9 consecutive cycles; done0 with last byte.
REQ-032 payload0=64'hFF00_0000_0000_0001 -> CRC byte 8'h07; byte_counter steps 0..8.
REQ-033 req0=req1=1 continuously -> grants alternate gnt0, gnt1, gnt0; spacing 14 cycles at GAP_CYCLES=4.
REQ-034 tx_ready low for 3 cycles during byte 3 -> tx_data/tx_valid held; frame completes with correct CRC, 3 cycles late.
REQ-035 reset asserted during byte 5 -> outputs at reset values immediately; no done; next request yields full 9-byte frame.
REQ-036 req1 pulsed during GAP only, dropped before IDLE -> no gnt1; busy falls after gap.
